// File: rtl/write_receiver.sv
// rtl/write_receiver.sv - ingress packet writer: one SRAM word per data beat, chain links, enqueue/drop descriptors
module write_receiver #(
  parameter int num_of_priorities  = 8,
  parameter int address_width      = 12,
  parameter int arbiter_data_width = 64,
  parameter int max_packet_words   = 64,
  localparam int PW = (num_of_priorities > 1) ? $clog2(num_of_priorities) : 1,
  localparam int LW = $clog2(max_packet_words + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_sop,
  input  logic                          wr_vld,
  input  logic                          wr_eop,
  input  logic [arbiter_data_width-1:0] wr_data,
  output logic                          wr_ready,
  input  logic                          address_valid,
  input  logic [address_width-1:0]      address_to_write,
  output logic                          address_request,
  output logic                          wea,
  output logic [address_width-1:0]      address_write,
  output logic [arbiter_data_width-1:0] data_write,
  output logic                          link_we,
  output logic [address_width-1:0]      link_from,
  output logic [address_width-1:0]      link_to,
  output logic                          pkt_done,
  output logic                          pkt_drop,
  output logic [PW-1:0]                 pkt_priority,
  output logic [address_width-1:0]      pkt_first_address,
  output logic [address_width-1:0]      pkt_last_address,
  output logic [LW-1:0]                 pkt_length
);

  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;

  state_t                          state_q;
  logic [PW-1:0]                   prio_q;
  logic [LW-1:0]                   len_q, len_d;
  logic [address_width-1:0]        first_q, first_d, last_q, last_d;
  logic                            accept;
  logic                            wea_q, link_we_q, done_q, drop_q;
  logic [address_width-1:0]        aw_q, lfrom_q, lto_q, dfirst_q, dlast_q;
  logic [arbiter_data_width-1:0]   dw_q;
  logic [PW-1:0]                   dprio_q;
  logic [LW-1:0]                   dlen_q;

  // A header cycle never carries a data word, so wr_sop blocks acceptance.
  always_comb begin
    accept  = rst && (state_q == DATA) && wr_vld && !wr_sop && address_valid &&
              (len_q != LW'(max_packet_words));
    len_d   = len_q + {{(LW-1){1'b0}}, accept};
    first_d = (accept && (len_q == '0)) ? address_to_write : first_q;
    last_d  = accept ? address_to_write : last_q;
  end

  assign wr_ready          = address_valid;
  assign address_request   = accept;
  assign wea               = wea_q;
  assign address_write     = aw_q;
  assign data_write        = dw_q;
  assign link_we           = link_we_q;
  assign link_from         = lfrom_q;
  assign link_to           = lto_q;
  assign pkt_done          = done_q;
  assign pkt_drop          = drop_q;
  assign pkt_priority      = dprio_q;
  assign pkt_first_address = dfirst_q;
  assign pkt_last_address  = dlast_q;
  assign pkt_length        = dlen_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      prio_q    <= '0;
      len_q     <= '0;
      first_q   <= '0;
      last_q    <= '0;
      wea_q     <= 1'b0;
      aw_q      <= '0;
      dw_q      <= '0;
      link_we_q <= 1'b0;
      lfrom_q   <= '0;
      lto_q     <= '0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
      dprio_q   <= '0;
      dfirst_q  <= '0;
      dlast_q   <= '0;
      dlen_q    <= '0;
    end else begin
      wea_q     <= accept;
      link_we_q <= accept && (len_q != '0);
      if (accept) begin
        aw_q <= address_to_write;
        dw_q <= wr_data;
      end
      if (accept && (len_q != '0)) begin
        lfrom_q <= last_q;
        lto_q   <= address_to_write;
      end
      len_q    <= len_d;
      first_q  <= first_d;
      last_q   <= last_d;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      dprio_q  <= '0;
      dfirst_q <= '0;
      dlast_q  <= '0;
      dlen_q   <= '0;

      if (wr_sop) begin
        // A new header while a packet is open aborts it like a dropped packet.
        if ((state_q != IDLE) && (len_q != '0)) begin
          drop_q   <= 1'b1;
          dprio_q  <= prio_q;
          dfirst_q <= first_q;
          dlast_q  <= last_q;
          dlen_q   <= len_q;
        end
        prio_q  <= wr_data[PW-1:0];
        len_q   <= '0;
        state_q <= DATA;
      end else begin
        case (state_q)
          DATA: begin
            if (wr_eop) begin
              if (wr_vld && !accept) begin
                drop_q <= (len_q != '0);
              end else begin
                done_q <= (len_d != '0);
              end
              if (len_d != '0) begin
                dprio_q  <= prio_q;
                dfirst_q <= first_d;
                dlast_q  <= last_d;
                dlen_q   <= len_d;
              end
              state_q <= IDLE;
            end else if (wr_vld && !accept) begin
              state_q <= DROP;
            end
          end
          DROP: begin
            if (wr_eop) begin
              if (len_q != '0) begin
                drop_q   <= 1'b1;
                dprio_q  <= prio_q;
                dfirst_q <= first_q;
                dlast_q  <= last_q;
                dlen_q   <= len_q;
              end
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_write_receiver.sv
// tb/tb_write_receiver.sv - table-driven bench for write_receiver plus long-packet and reset sequences
module tb_write_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_sop, wr_vld, wr_eop;
  logic [63:0] wr_data;
  logic        wr_ready;
  logic        address_valid;
  logic [11:0] address_to_write;
  logic        address_request;
  logic        wea;
  logic [11:0] address_write;
  logic [63:0] data_write;
  logic        link_we;
  logic [11:0] link_from, link_to;
  logic        pkt_done, pkt_drop;
  logic [2:0]  pkt_priority;
  logic [11:0] pkt_first_address, pkt_last_address;
  logic [6:0]  pkt_length;

  int checks = 0;
  int errors = 0;

  write_receiver #(
    .num_of_priorities(8), .address_width(12), .arbiter_data_width(64), .max_packet_words(64)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_sop(wr_sop), .wr_vld(wr_vld), .wr_eop(wr_eop), .wr_data(wr_data),
    .wr_ready(wr_ready),
    .address_valid(address_valid), .address_to_write(address_to_write),
    .address_request(address_request),
    .wea(wea), .address_write(address_write), .data_write(data_write),
    .link_we(link_we), .link_from(link_from), .link_to(link_to),
    .pkt_done(pkt_done), .pkt_drop(pkt_drop), .pkt_priority(pkt_priority),
    .pkt_first_address(pkt_first_address), .pkt_last_address(pkt_last_address),
    .pkt_length(pkt_length)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sop, vld, eop;
    logic [63:0] data;
    logic        av;
    logic [11:0] addr;
    logic        req, wea;
    logic [11:0] aw;
    logic        lwe;
    logic [11:0] lfrom;
    logic        done, drop;
    logic [2:0]  prio;
    logic [11:0] first, last;
    logic [6:0]  len;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic v(input logic sop, input logic vld, input logic eop, input logic [63:0] data,
                   input logic av, input logic [11:0] addr, input logic req, input logic we,
                   input logic [11:0] aw, input logic lwe, input logic [11:0] lfrom,
                   input logic done, input logic drop, input logic [2:0] prio,
                   input logic [11:0] first, input logic [11:0] last, input logic [6:0] len);
    vec_t r;
    r.sop = sop; r.vld = vld; r.eop = eop; r.data = data; r.av = av; r.addr = addr;
    r.req = req; r.wea = we; r.aw = aw; r.lwe = lwe; r.lfrom = lfrom;
    r.done = done; r.drop = drop; r.prio = prio; r.first = first; r.last = last; r.len = len;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic sop, input logic vld, input logic eop, input logic [63:0] data,
                       input logic av, input logic [11:0] addr);
    wr_sop = sop; wr_vld = vld; wr_eop = eop; wr_data = data;
    address_valid = av; address_to_write = addr;
  endtask

  task automatic run_row(input int i, input vec_t r);
    @(negedge clk);
    drive(r.sop, r.vld, r.eop, r.data, r.av, r.addr);
    #1 chk($sformatf("row%0d_req", i), address_request, r.req);
    @(posedge clk);
    #1;
    chk($sformatf("row%0d_wea", i), wea, r.wea);
    if (r.wea) begin
      chk($sformatf("row%0d_addr_write", i), address_write, r.aw);
      chk($sformatf("row%0d_data_write", i), data_write, r.data);
    end
    chk($sformatf("row%0d_link_we", i), link_we, r.lwe);
    if (r.lwe) begin
      chk($sformatf("row%0d_link_from", i), link_from, r.lfrom);
      chk($sformatf("row%0d_link_to", i), link_to, r.aw);
    end
    chk($sformatf("row%0d_done", i), pkt_done, r.done);
    chk($sformatf("row%0d_drop", i), pkt_drop, r.drop);
    if (r.done || r.drop) begin
      chk($sformatf("row%0d_prio", i), pkt_priority, r.prio);
      chk($sformatf("row%0d_first", i), pkt_first_address, r.first);
      chk($sformatf("row%0d_last", i), pkt_last_address, r.last);
      chk($sformatf("row%0d_len", i), pkt_length, r.len);
    end
  endtask

  task automatic long_pkt(input string tag, input int words, input logic [11:0] base,
                          input logic exp_done, input logic exp_drop);
    int wcount;
    wcount = 0;
    @(negedge clk);
    drive(1, 0, 0, 64'd4, 1, base);
    for (int i = 0; i < words; i++) begin
      @(negedge clk);
      drive(0, 1, 0, 64'h1000 + 64'(i), 1, base + 12'(i));
      #1 chk($sformatf("%s_req%0d", tag, i), address_request, (i < 64));
      @(posedge clk);
      #1 if (wea) wcount++;
    end
    @(negedge clk);
    drive(0, 0, 1, 64'd0, 1, base + 12'(words));
    @(posedge clk);
    #1;
    chk({tag, "_wea_count"}, wcount, 64);
    chk({tag, "_done"}, pkt_done, exp_done);
    chk({tag, "_drop"}, pkt_drop, exp_drop);
    chk({tag, "_prio"}, pkt_priority, 4);
    chk({tag, "_first"}, pkt_first_address, base);
    chk({tag, "_last"}, pkt_last_address, base + 12'd63);
    chk({tag, "_len"}, pkt_length, 64);
  endtask

  initial begin
    // packet prio 5, four words at 0x010..0x013
    v(1,0,0,5,1,'h010,        0,0,0,0,0,        0,0,0,0,0,0);
    v(0,1,0,'hA0,1,'h010,     1,1,'h010,0,0,    0,0,0,0,0,0);
    v(0,1,0,'hA1,1,'h011,     1,1,'h011,1,'h010,0,0,0,0,0,0);
    v(0,1,0,'hA2,1,'h012,     1,1,'h012,1,'h011,0,0,0,0,0,0);
    v(0,1,0,'hA3,1,'h013,     1,1,'h013,1,'h012,0,0,0,0,0,0);
    v(0,0,1,0,1,'h014,        0,0,0,0,0,        1,0,5,'h010,'h013,4);
    // address_valid drops on word 3 of 5
    v(1,0,0,1,1,'h020,        0,0,0,0,0,        0,0,0,0,0,0);
    v(0,1,0,'hB0,1,'h020,     1,1,'h020,0,0,    0,0,0,0,0,0);
    v(0,1,0,'hB1,1,'h021,     1,1,'h021,1,'h020,0,0,0,0,0,0);
    v(0,1,0,'hB2,0,'h022,     0,0,0,0,0,        0,0,0,0,0,0);
    v(0,1,0,'hB3,1,'h022,     0,0,0,0,0,        0,0,0,0,0,0);
    v(0,1,0,'hB4,1,'h022,     0,0,0,0,0,        0,0,0,0,0,0);
    v(0,0,1,0,1,'h022,        0,0,0,0,0,        0,1,1,'h020,'h021,2);
    // sop without eop aborts the open packet
    v(1,0,0,2,1,'h030,        0,0,0,0,0,        0,0,0,0,0,0);
    v(0,1,0,'hC0,1,'h030,     1,1,'h030,0,0,    0,0,0,0,0,0);
    v(0,1,0,'hC1,1,'h031,     1,1,'h031,1,'h030,0,0,0,0,0,0);
    v(1,0,0,7,1,'h032,        0,0,0,0,0,        0,1,2,'h030,'h031,2);
    v(0,1,0,'hC2,1,'h032,     1,1,'h032,0,0,    0,0,0,0,0,0);
    v(0,0,1,0,1,'h033,        0,0,0,0,0,        1,0,7,'h032,'h032,1);
    // eop then sop on the very next cycle, then sop directly followed by eop
    v(1,0,0,3,1,'h040,        0,0,0,0,0,        0,0,0,0,0,0);
    v(0,1,0,'hD0,1,'h040,     1,1,'h040,0,0,    0,0,0,0,0,0);
    v(0,0,1,0,1,'h041,        0,0,0,0,0,        1,0,3,'h040,'h040,1);
    v(1,0,0,4,1,'h041,        0,0,0,0,0,        0,0,0,0,0,0);
    v(0,1,0,'hD1,1,'h041,     1,1,'h041,0,0,    0,0,0,0,0,0);
    v(0,1,0,'hD2,1,'h042,     1,1,'h042,1,'h041,0,0,0,0,0,0);
    v(0,1,0,'hD3,1,'h043,     1,1,'h043,1,'h042,0,0,0,0,0,0);
    v(0,0,1,0,1,'h044,        0,0,0,0,0,        1,0,4,'h041,'h043,3);
    v(1,0,0,6,1,'h044,        0,0,0,0,0,        0,0,0,0,0,0);
    v(0,0,1,0,1,'h044,        0,0,0,0,0,        0,0,0,0,0,0);
    // last word coincident with eop is counted
    v(1,0,0,6,1,'h050,        0,0,0,0,0,        0,0,0,0,0,0);
    v(0,1,0,'hE0,1,'h050,     1,1,'h050,0,0,    0,0,0,0,0,0);
    v(0,1,1,'hE1,1,'h051,     1,1,'h051,1,'h050,1,0,6,'h050,'h051,2);
    // vld/eop in IDLE and vld on the header cycle are ignored
    v(0,1,0,'hF0,1,'h060,     0,0,0,0,0,        0,0,0,0,0,0);
    v(0,0,1,0,1,'h060,        0,0,0,0,0,        0,0,0,0,0,0);
    v(1,1,0,3,1,'h060,        0,0,0,0,0,        0,0,0,0,0,0);
    v(0,0,1,0,1,'h060,        0,0,0,0,0,        0,0,0,0,0,0);

    rst = 1'b0;
    drive(0, 0, 0, 64'd0, 1, 12'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wea", wea, 0);
    chk("reset_link_we", link_we, 0);
    chk("reset_done", pkt_done, 0);
    chk("reset_drop", pkt_drop, 0);
    chk("reset_addr_write", address_write, 0);
    chk("reset_data_write", data_write, 0);
    chk("reset_len", pkt_length, 0);
    chk("reset_req", address_request, 0);
    chk("wr_ready_follows_av", wr_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 64'd0, 0, 12'h0);
    #1 chk("wr_ready_low", wr_ready, 0);

    for (int i = 0; i < tbl.size(); i++) run_row(i, tbl[i]);

    long_pkt("len65", 65, 12'h100, 1'b0, 1'b1);
    long_pkt("len64", 64, 12'h200, 1'b1, 1'b0);

    // reset in the middle of a packet
    @(negedge clk); drive(1, 0, 0, 64'd3, 1, 12'h070);
    @(negedge clk); drive(0, 1, 0, 64'h77, 1, 12'h070);
    @(negedge clk); drive(0, 1, 0, 64'h78, 1, 12'h071);
    @(negedge clk); rst = 1'b0; drive(0, 0, 0, 64'd0, 1, 12'h072);
    @(posedge clk);
    #1;
    chk("midrst_wea", wea, 0);
    chk("midrst_link_we", link_we, 0);
    chk("midrst_link_from", link_from, 0);
    chk("midrst_link_to", link_to, 0);
    chk("midrst_addr_write", address_write, 0);
    chk("midrst_data_write", data_write, 0);
    chk("midrst_drop", pkt_drop, 0);
    chk("midrst_done", pkt_done, 0);
    @(negedge clk); rst = 1'b1; drive(0, 0, 1, 64'd0, 1, 12'h072);
    @(posedge clk);
    #1;
    chk("post_rst_eop_done", pkt_done, 0);
    chk("post_rst_eop_drop", pkt_drop, 0);
    @(negedge clk); drive(1, 0, 0, 64'd2, 1, 12'h080);
    @(negedge clk); drive(0, 1, 0, 64'h88, 1, 12'h080);
    @(posedge clk);
    #1;
    chk("post_rst_wea", wea, 1);
    chk("post_rst_addr", address_write, 12'h080);
    @(negedge clk); drive(0, 0, 1, 64'd0, 1, 12'h081);
    @(posedge clk);
    #1;
    chk("post_rst_done", pkt_done, 1);
    chk("post_rst_prio", pkt_priority, 2);
    chk("post_rst_first", pkt_first_address, 12'h080);
    chk("post_rst_len", pkt_length, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_receiver.md
# write_receiver

Ingress-side counterpart of the read arbiter in the SRAM controller: accepts one port's packet stream (sop/vld/eop framing, the same framing the read arbiter emits), takes a free SRAM address per data word from the address manager, and writes each word into SRAM. At packet end it hands the manager a descriptor (priority, first/last address, length) for enqueue, or a drop descriptor so the allocated chain is reclaimed. Between words it emits link writes so the manager can build the packet's address chain.

## Interface
- num_of_priorities, 8: priority classes; priority field width PW = clog2(num_of_priorities)
- address_width, 12: SRAM word address width
- arbiter_data_width, 64: data word width
- max_packet_words, 64: max data words per packet; length width LW = clog2(max_packet_words+1)

- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset, sampled on clk rising edge)
- wr_sop  in  1  header cycle; wr_data[PW-1:0] carries packet priority
- wr_vld  in  1  data word valid on wr_data
- wr_eop  in  1  end-of-packet pulse, cycle after last wr_vld
- wr_data  in  arbiter_data_width  header/data
- wr_ready  out  1  combinational = address_valid; upstream must not start a packet while low
- address_valid  in  1  manager has a free address on address_to_write
- address_to_write  in  address_width  next free address
- address_request  out  1  combinational; consumes address_to_write this cycle
- wea  out  1  SRAM write enable
- address_write  out  address_width  SRAM write address
- data_write  out  arbiter_data_width  SRAM write data
- link_we  out  1  chain link write
- link_from / link_to  out  address_width  previous / current word address
- pkt_done  out  1  packet committed pulse
- pkt_drop  out  1  packet dropped pulse (reclaim chain)
- pkt_priority  out  PW  descriptor priority
- pkt_first_address / pkt_last_address  out  address_width  chain ends
- pkt_length  out  LW  words written

## Operation
- States: IDLE, DATA, DROP.
- IDLE: wr_sop=1 -> latch priority = wr_data[PW-1:0], length=0, go DATA. wr_vld/wr_eop in IDLE ignored. wr_vld coincident with wr_sop ignored (sop cycle is header only).
- DATA, wr_vld=1:
  - address_valid=1 and length<max_packet_words: address_request=1; word written; length+1; first word latches first address; every word updates last address; non-first words issue link (link_from=previous address, link_to=current).
  - address_valid=0 or length==max_packet_words: word not written, no request, go DROP.
- DROP: further wr_vld ignored, no requests.
- wr_eop in DATA, length>0: pkt_done with descriptor; -> IDLE. length==0: no pulse; -> IDLE.
- wr_eop in DROP: length>0 -> pkt_drop with descriptor of words actually written; length==0 -> no pulse; -> IDLE.
- wr_sop in DATA/DROP (missing eop): abort current packet as per eop in DROP (pkt_drop if length>0), then start new packet with new priority; stay/go DATA.
- wr_eop and wr_vld same cycle: vld word processed first, then eop (word counts in descriptor).
- address_request never asserted outside DATA.

## Timing
- Reset (rst=0): state IDLE; wea, link_we, pkt_done, pkt_drop, address_request(registered terms) = 0; address_write, data_write, link_from, link_to, pkt_* = 0. Mid-packet reset discards packet with no pulse.
- Data word at cycle T -> wea=1, address_write, data_write at T+1 (one-cycle registered). link_we at T+1 for non-first words.
- wr_eop at cycle E -> pkt_done/pkt_drop one-cycle pulse at E+1, descriptor valid only that cycle; state IDLE at E+1, so wr_sop accepted at E+1.
- address_request same cycle as accepted wr_vld; manager presents next address next cycle.
- Back-to-back vld words: one write per cycle, no bubbles.

## Test plan
- Priority 5, 4 words, address_valid=1, addresses 0x010..0x013 -> 4 wea at T+1 each; links 0x010->0x011, 0x011->0x012, 0x012->0x013; pkt_done with prio 5, first 0x010, last 0x013, length 4 at eop+1.
- address_valid drops on word 3 of 5 -> 2 words written, no further requests; pkt_drop first/last = first two addresses, length 2.
- 65 words with max_packet_words=64 -> 64 written, pkt_drop length 64; 64 words -> pkt_done length 64.
- wr_sop(prio 2), 2 words, wr_sop(prio 7) without eop, 1 word, eop -> pkt_drop length 2 at second sop+1; pkt_done prio 7 length 1.
- eop at E, sop at E+1, 3 words -> both packets pkt_done, no lost word; sop followed directly by eop -> no pulses.
- rst=0 mid-packet after 2 words -> all outputs 0 next cycle, no pkt pulses; next packet normal.
